// File: rtl/oc8051_sfr_bank.sv
// oc8051_sfr_bank
//   Generic bank of NREG special function registers that sits at BASE_ADR in
//   the 8051 SFR space (0x80-0xFF). Supports byte and bit read/write, a one-cycle
//   read-after-write stall, and hardware-set sticky status bits. An optional
//   clock prescaler is built when OC8051_SFR_BANK_PRES_EN is defined; otherwise
//   pres_ow is tied low.
//
// Ports
//   clk, rst    system clock, asynchronous active-high reset
//   adr0        read address (byte or bit)
//   adr1        write address (byte or bit)
//   dat1        byte write data
//   bit_in      bit write data
//   we          write enable
//   wr_bit      write is a bit write (registered internally as wr_bit_r)
//   hw_set      per-bit hardware set pulses, byte k = bits [8k+7:8k]
//   dat0        registered byte read data
//   bit_out     registered bit read data
//   hit         registered: previous adr0 decoded into this bank
//   wait_data   read hazard stall
//   regs        live register contents
//   pres_ow     prescaler overflow pulse
module oc8051_sfr_bank #(
  parameter logic [7:0]          BASE_ADR = 8'hC0,
  parameter int                  NREG     = 8,
  parameter logic [8*NREG-1:0]   RST_VAL  = {8*NREG{1'b0}},
  parameter logic [8*NREG-1:0]   WMASK    = {8*NREG{1'b1}},
  parameter int                  PRES_DIV = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          adr0,
  input  logic [7:0]          adr1,
  input  logic [7:0]          dat1,
  input  logic                bit_in,
  input  logic                we,
  input  logic                wr_bit,
  input  logic [8*NREG-1:0]   hw_set,
  output logic [7:0]          dat0,
  output logic                bit_out,
  output logic                hit,
  output logic                wait_data,
  output logic [8*NREG-1:0]   regs,
  output logic                pres_ow
);

  logic [7:0] reg_q [NREG];
  logic [7:0] reg_d [NREG];
  logic [7:0] wm_b  [NREG];
  logic       wr_bit_r;

  logic [7:0] rd_byte;
  logic       rd_hit;
  logic [7:0] row0_byte;
  logic [7:0] row0_mask;
  logic       row0_hit;
  logic [7:0] wr_byte;
  logic [7:0] wr_mask;
  logic       wr_hit;
  logic [7:0] fwd_byte;
  logic       bit_nxt;
  logic       hazard;

  function automatic logic [7:0] reg_adr(input int k);
    return BASE_ADR + k[7:0];
  endfunction

  for (genvar g = 0; g < NREG; g++) begin : g_map
    assign wm_b[g]          = WMASK[8*g +: 8];
    assign regs[8*g +: 8]   = reg_q[g];
  end

  // Address decode for the read byte, the bit-read row and the write target.
  // The bit row {adr[7:3],000} is bit-addressable by construction.
  always_comb begin
    rd_byte   = 8'h00;
    rd_hit    = 1'b0;
    row0_byte = 8'h00;
    row0_mask = 8'h00;
    row0_hit  = 1'b0;
    wr_byte   = 8'h00;
    wr_mask   = 8'h00;
    wr_hit    = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      if (adr0 == reg_adr(k)) begin
        rd_byte = reg_q[k];
        rd_hit  = 1'b1;
      end
      if ({adr0[7:3], 3'b000} == reg_adr(k)) begin
        row0_byte = reg_q[k];
        row0_mask = wm_b[k];
        row0_hit  = 1'b1;
      end
      if (adr1 == reg_adr(k)) begin
        wr_byte = reg_q[k];
        wr_mask = wm_b[k];
        wr_hit  = 1'b1;
      end
    end
  end

  // Register update: software write first, hardware set last so a set pulse
  // always survives a simultaneous software write of 0.
  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      reg_d[k] = reg_q[k];
      if (we && !wr_bit_r && adr1 == reg_adr(k))
        reg_d[k] = (reg_q[k] & ~wm_b[k]) | (dat1 & wm_b[k]);
      if (we && wr_bit_r && {adr1[7:3], 3'b000} == reg_adr(k) && wm_b[k][adr1[2:0]])
        reg_d[k][adr1[2:0]] = bit_in;
      reg_d[k] = reg_d[k] | hw_set[8*k +: 8];
    end
  end

  // Bit read with write forwarding; forwarded data keeps read-only bits at
  // their current value.
  always_comb begin
    fwd_byte = (wr_byte & ~wr_mask) | (dat1 & wr_mask);
    bit_nxt  = row0_hit & row0_byte[adr0[2:0]];
    if (we && !wr_bit_r && wr_hit && adr1[7:3] == adr0[7:3] && adr1[2:0] != 3'b111)
      bit_nxt = fwd_byte[adr0[2:0]];
    else if (we && wr_bit_r && adr1 == adr0)
      bit_nxt = row0_hit & (row0_mask[adr0[2:0]] ? bit_in : row0_byte[adr0[2:0]]);
  end

  assign hazard = we & ((~wr_bit_r & adr1[7] & (adr1 == adr0)) |
                        ( wr_bit_r & (adr1[7:3] == adr0[7:3])));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++)
        reg_q[k] <= RST_VAL[8*k +: 8];
      wr_bit_r  <= 1'b0;
      dat0      <= 8'h00;
      bit_out   <= 1'b0;
      hit       <= 1'b0;
      wait_data <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++)
        reg_q[k] <= reg_d[k];
      wr_bit_r <= wr_bit;
      bit_out  <= bit_nxt;
      // A stall lasts one cycle: dat0/hit hold, then pick up the written value.
      if (hazard && !wait_data) begin
        wait_data <= 1'b1;
      end else begin
        wait_data <= 1'b0;
        dat0      <= rd_byte;
        hit       <= rd_hit;
      end
    end
  end

`ifdef OC8051_SFR_BANK_PRES_EN
  localparam int CW = $clog2(PRES_DIV);
  logic [CW-1:0] pres_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pres_cnt <= '0;
      pres_ow  <= 1'b0;
    end else if (pres_cnt == CW'(PRES_DIV - 1)) begin
      pres_cnt <= '0;
      pres_ow  <= 1'b1;
    end else begin
      pres_cnt <= pres_cnt + CW'(1);
      pres_ow  <= 1'b0;
    end
  end
`else
  assign pres_ow = 1'b0;
`endif

endmodule
